// File: rtl/mem_ctrl_pkg.sv
// Shared memory-controller types: command encoding, scheduler states, bank table entry,
// address geometry and a small width helper.
package mem_ctrl_pkg;

  localparam int unsigned BANK_GROUPS     = 2;
  localparam int unsigned BANKS_PER_GROUP = 4;
  localparam int unsigned ROW_BITS        = 8;
  localparam int unsigned COL_BITS        = 4;
  localparam int unsigned PADDR_BITS      = 19;
  localparam int unsigned BEATS           = 8;
  localparam int unsigned BEAT_BITS       = 64;

  localparam int unsigned BG_BITS   = $clog2(BANK_GROUPS);
  localparam int unsigned BA_BITS   = $clog2(BANKS_PER_GROUP);
  localparam int unsigned BANK_BITS = BG_BITS + BA_BITS;
  localparam int unsigned NUM_BANKS = BANK_GROUPS * BANKS_PER_GROUP;

  typedef logic [BEATS-1:0][BEAT_BITS-1:0] line_t;

  // Encoding is shared with command_sender; do not reorder.
  typedef enum logic [2:0] {
    CmdRead      = 3'b000,
    CmdWrite     = 3'b001,
    CmdActivate  = 3'b010,
    CmdPrecharge = 3'b011
  } mem_cmd_e;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StPreWait,
    StAct,
    StActWait,
    StCas,
    StBusWait
  } sched_state_e;

  typedef struct packed {
    logic                valid;
    logic [ROW_BITS-1:0] row;
  } bank_entry_t;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bank_cmd_scheduler_if.sv
// Request and command bundle of the bank command scheduler.
interface bank_cmd_scheduler_if;
  import mem_ctrl_pkg::*;

  logic                    req_valid_in;
  logic                    req_ready_out;
  logic                    req_write_in;
  logic [PADDR_BITS-1:0]   req_addr_in;
  line_t                   req_wdata_in;
  logic                    cmd_valid_out;
  mem_cmd_e                cmd_out;
  logic [BG_BITS-1:0]      bg_out;
  logic [BA_BITS-1:0]      ba_out;
  logic [ROW_BITS-1:0]     row_out;
  logic [COL_BITS-1:0]     col_out;
  line_t                   wdata_out;

  // Requester side.
  modport master (
    output req_valid_in, req_write_in, req_addr_in, req_wdata_in,
    input  req_ready_out, cmd_valid_out, cmd_out, bg_out, ba_out, row_out, col_out, wdata_out
  );

  // Scheduler side.
  modport slave (
    input  req_valid_in, req_write_in, req_addr_in, req_wdata_in,
    output req_ready_out, cmd_valid_out, cmd_out, bg_out, ba_out, row_out, col_out, wdata_out
  );

endinterface

// File: rtl/address_parser.sv
// Splits a byte address into column, bank, bank group and row fields.
module address_parser
  import mem_ctrl_pkg::*;
(
  input  logic [PADDR_BITS-1:0] addr_in,
  output logic [ROW_BITS-1:0]   row_out,
  output logic [COL_BITS-1:0]   col_out,
  output logic [BA_BITS-1:0]    ba_out,
  output logic [BG_BITS-1:0]    bg_out
);

  localparam int unsigned COL_LSB = 3;
  localparam int unsigned BA_LSB  = COL_LSB + COL_BITS;
  localparam int unsigned BG_LSB  = BA_LSB + BA_BITS;
  localparam int unsigned ROW_LSB = BG_LSB + BG_BITS;

  assign col_out = addr_in[BA_LSB-1:COL_LSB];
  assign ba_out  = addr_in[BG_LSB-1:BA_LSB];
  assign bg_out  = addr_in[ROW_LSB-1:BG_LSB];
  assign row_out = addr_in[ROW_LSB+ROW_BITS-1:ROW_LSB];

  // Byte offset within a beat and the top address bit carry no DRAM coordinate.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_in[PADDR_BITS-1:ROW_LSB+ROW_BITS], addr_in[COL_LSB-1:0]};

endmodule

// File: rtl/bank_cmd_scheduler.sv
// Open-page command scheduler: one request at a time, PRE/ACT/CAS with bank timing,
// then holds off until the data burst of the CAS has left the bus.
module bank_cmd_scheduler
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned CAS_LATENCY        = 22,
  parameter int unsigned ACTIVATION_LATENCY = 8,
  parameter int unsigned PRECHARGE_LATENCY  = 5,
  parameter int unsigned BURST_CYCLES       = 8
) (
  input logic                 clk_in,
  input logic                 rst_in,
  bank_cmd_scheduler_if.slave bus
);

  localparam int unsigned RD_WAIT  = CAS_LATENCY + BURST_CYCLES;
  localparam int unsigned CNT_BITS =
      $clog2(max3(RD_WAIT, ACTIVATION_LATENCY, PRECHARGE_LATENCY) + 1);

  sched_state_e state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  logic                write_q;
  logic [ROW_BITS-1:0] row_q;
  logic [COL_BITS-1:0] col_q;
  logic [BA_BITS-1:0]  ba_q;
  logic [BG_BITS-1:0]  bg_q;
  line_t               wdata_q;

  bank_entry_t [NUM_BANKS-1:0] table_q;

  logic                cmd_valid_q;
  mem_cmd_e            cmd_q;
  logic [BG_BITS-1:0]  cmd_bg_q;
  logic [BA_BITS-1:0]  cmd_ba_q;
  logic [ROW_BITS-1:0] cmd_row_q;
  logic [COL_BITS-1:0] cmd_col_q;

  logic [ROW_BITS-1:0] p_row;
  logic [COL_BITS-1:0] p_col;
  logic [BA_BITS-1:0]  p_ba;
  logic [BG_BITS-1:0]  p_bg;

  address_parser u_address_parser (
    .addr_in (bus.req_addr_in),
    .row_out (p_row),
    .col_out (p_col),
    .ba_out  (p_ba),
    .bg_out  (p_bg)
  );

  logic accept;
  assign accept = (state_q == StIdle) && bus.req_valid_in;

  // While idle the live request is decoded; afterwards the latched copy is used.
  logic                idle;
  logic                cur_write;
  logic [ROW_BITS-1:0] cur_row;
  logic [COL_BITS-1:0] cur_col;
  logic [BA_BITS-1:0]  cur_ba;
  logic [BG_BITS-1:0]  cur_bg;
  logic [BANK_BITS-1:0] bank_idx;
  bank_entry_t         cur_entry;

  assign idle      = (state_q == StIdle);
  assign cur_write = idle ? bus.req_write_in : write_q;
  assign cur_row   = idle ? p_row : row_q;
  assign cur_col   = idle ? p_col : col_q;
  assign cur_ba    = idle ? p_ba  : ba_q;
  assign cur_bg    = idle ? p_bg  : bg_q;
  assign bank_idx  = {cur_bg, cur_ba};
  assign cur_entry = table_q[bank_idx];

  logic                issue;
  mem_cmd_e            issue_cmd;
  logic [ROW_BITS-1:0] issue_row;
  mem_cmd_e            cas_cmd;

  assign cas_cmd = cur_write ? CmdWrite : CmdRead;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    issue     = 1'b0;
    issue_cmd = CmdRead;
    issue_row = cur_row;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          issue = 1'b1;
          if (!cur_entry.valid) begin
            state_d   = StAct;
            issue_cmd = CmdActivate;
          end else if (cur_entry.row == cur_row) begin
            state_d   = StCas;
            issue_cmd = cas_cmd;
          end else begin
            // Precharge closes the row that is currently open.
            state_d   = StPre;
            issue_cmd = CmdPrecharge;
            issue_row = cur_entry.row;
          end
        end
      end
      StPre: begin
        state_d = StPreWait;
        cnt_d   = CNT_BITS'(PRECHARGE_LATENCY - 1);
      end
      StPreWait: begin
        if (cnt_q == CNT_BITS'(1)) begin
          state_d   = StAct;
          issue     = 1'b1;
          issue_cmd = CmdActivate;
        end else begin
          cnt_d = cnt_q - CNT_BITS'(1);
        end
      end
      StAct: begin
        state_d = StActWait;
        cnt_d   = CNT_BITS'(ACTIVATION_LATENCY - 1);
      end
      StActWait: begin
        if (cnt_q == CNT_BITS'(1)) begin
          state_d   = StCas;
          issue     = 1'b1;
          issue_cmd = cas_cmd;
        end else begin
          cnt_d = cnt_q - CNT_BITS'(1);
        end
      end
      StCas: begin
        state_d = StBusWait;
        cnt_d   = write_q ? CNT_BITS'(BURST_CYCLES - 1) : CNT_BITS'(RD_WAIT - 1);
      end
      StBusWait: begin
        if (cnt_q == CNT_BITS'(1)) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CNT_BITS'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      ba_q        <= '0;
      bg_q        <= '0;
      wdata_q     <= '0;
      table_q     <= '0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= CmdRead;
      cmd_bg_q    <= '0;
      cmd_ba_q    <= '0;
      cmd_row_q   <= '0;
      cmd_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_valid_q <= issue;
      if (accept) begin
        write_q <= bus.req_write_in;
        row_q   <= p_row;
        col_q   <= p_col;
        ba_q    <= p_ba;
        bg_q    <= p_bg;
        if (bus.req_write_in) begin
          wdata_q <= bus.req_wdata_in;
        end
      end
      if (issue) begin
        cmd_q     <= issue_cmd;
        cmd_bg_q  <= cur_bg;
        cmd_ba_q  <= cur_ba;
        cmd_row_q <= issue_row;
        cmd_col_q <= cur_col;
        if (issue_cmd == CmdPrecharge) begin
          table_q[bank_idx].valid <= 1'b0;
        end else if (issue_cmd == CmdActivate) begin
          table_q[bank_idx].valid <= 1'b1;
          table_q[bank_idx].row   <= cur_row;
        end
      end
    end
  end

  assign bus.req_ready_out = idle;
  assign bus.cmd_valid_out = cmd_valid_q;
  assign bus.cmd_out       = cmd_q;
  assign bus.bg_out        = cmd_bg_q;
  assign bus.ba_out        = cmd_ba_q;
  assign bus.row_out       = cmd_row_q;
  assign bus.col_out       = cmd_col_q;
  assign bus.wdata_out     = wdata_q;

endmodule
